// File: rtl/nios2_nios2_div_cell_if.sv
// Request/response bundle between a divide requester and the divide cell.
// The master drives operands and the start strobe; the slave (the cell)
// returns busy, done and the registered quotient/remainder.
interface nios2_nios2_div_cell_if #(
    parameter int DIV_WIDTH = 32
);
    logic [DIV_WIDTH-1:0] M_div_src1;
    logic [DIV_WIDTH-1:0] M_div_src2;
    logic                 M_div_signed;
    logic                 M_div_start;
    logic                 M_div_busy;
    logic                 M_div_done;
    logic [DIV_WIDTH-1:0] M_div_cell_result;
    logic [DIV_WIDTH-1:0] M_div_cell_remainder;

    modport master (
        output M_div_src1,
        output M_div_src2,
        output M_div_signed,
        output M_div_start,
        input  M_div_busy,
        input  M_div_done,
        input  M_div_cell_result,
        input  M_div_cell_remainder
    );

    modport slave (
        input  M_div_src1,
        input  M_div_src2,
        input  M_div_signed,
        input  M_div_start,
        output M_div_busy,
        output M_div_done,
        output M_div_cell_result,
        output M_div_cell_remainder
    );
endinterface

// File: rtl/nios2_nios2_div_cell.sv
// Fixed-latency radix-2 restoring divider for signed (div) and unsigned
// (divu) operation. Works on magnitudes for DIV_WIDTH cycles, then applies
// the latched signs in a single fix-up cycle. A zero divisor runs the same
// schedule; its quotient is forced to all ones while the remainder falls
// out of the datapath as the original dividend.
module nios2_nios2_div_cell #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    nios2_nios2_div_cell_if.slave        bus
);

    localparam int CW = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    // Two's complement negation with natural wrap.
    function automatic logic [DIV_WIDTH-1:0] f_neg(input logic [DIV_WIDTH-1:0] x);
        f_neg = (~x) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; raw value in unsigned mode.
    function automatic logic [DIV_WIDTH-1:0] f_mag(input logic [DIV_WIDTH-1:0] x,
                                                   input logic                 is_signed);
        f_mag = (is_signed && x[DIV_WIDTH-1]) ? f_neg(x) : x;
    endfunction

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DIV_WIDTH-1:0]  r_rem;      // partial remainder magnitude
    logic [DIV_WIDTH-1:0]  r_dvd;      // dividend shifts out, quotient shifts in
    logic [DIV_WIDTH-1:0]  r_div;      // divisor magnitude
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_dz;
    logic                  r_busy;
    logic                  r_done;
    logic [DIV_WIDTH-1:0]  r_result;
    logic [DIV_WIDTH-1:0]  r_remainder;

    logic [DIV_WIDTH:0]    w_shift;
    logic [DIV_WIDTH:0]    w_diff;
    logic                  w_sub_ok;
    logic [DIV_WIDTH-1:0]  w_rem_next;
    logic [DIV_WIDTH-1:0]  w_dvd_next;
    logic [DIV_WIDTH-1:0]  w_q_fix;
    logic [DIV_WIDTH-1:0]  w_r_fix;

    // One restoring step: the shifted remainder is below twice the divisor,
    // so a (DIV_WIDTH+1)-bit signed trial difference cannot overflow and its
    // top bit is the restore decision.
    always_comb begin
        w_shift    = {r_rem, r_dvd[DIV_WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_div};
        w_sub_ok   = ~w_diff[DIV_WIDTH];
        w_rem_next = w_sub_ok ? w_diff[DIV_WIDTH-1:0] : w_shift[DIV_WIDTH-1:0];
        w_dvd_next = {r_dvd[DIV_WIDTH-2:0], w_sub_ok};
    end

    // Sign application; a zero divisor overrides the quotient with all ones.
    always_comb begin
        w_q_fix = {DIV_WIDTH{1'b0}};
        w_r_fix = {DIV_WIDTH{1'b0}};
        if (r_dz) begin
            w_q_fix = {DIV_WIDTH{1'b1}};
        end else if (r_q_neg) begin
            w_q_fix = f_neg(r_dvd);
        end else begin
            w_q_fix = r_dvd;
        end
        if (r_r_neg) begin
            w_r_fix = f_neg(r_rem);
        end else begin
            w_r_fix = r_rem;
        end
    end

    // Control FSM and datapath registers, including all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_rem       <= {DIV_WIDTH{1'b0}};
            r_dvd       <= {DIV_WIDTH{1'b0}};
            r_div       <= {DIV_WIDTH{1'b0}};
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dz        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= {DIV_WIDTH{1'b0}};
            r_remainder <= {DIV_WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.M_div_start) begin
                        r_rem   <= {DIV_WIDTH{1'b0}};
                        r_dvd   <= f_mag(bus.M_div_src1, bus.M_div_signed);
                        r_div   <= f_mag(bus.M_div_src2, bus.M_div_signed);
                        r_q_neg <= bus.M_div_signed &
                                   (bus.M_div_src1[DIV_WIDTH-1] ^ bus.M_div_src2[DIV_WIDTH-1]);
                        r_r_neg <= bus.M_div_signed & bus.M_div_src1[DIV_WIDTH-1];
                        r_dz    <= (bus.M_div_src2 == {DIV_WIDTH{1'b0}});
                        r_cnt   <= CW'(DIV_WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state <= FIXUP;
                    end else begin
                        r_cnt   <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                        r_state <= CALC;
                    end
                end
                FIXUP: begin
                    r_result    <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.M_div_busy           = r_busy;
    assign bus.M_div_done           = r_done;
    assign bus.M_div_cell_result    = r_result;
    assign bus.M_div_cell_remainder = r_remainder;

endmodule
